fp_mant_normalizer: RTL
=======================

// Module: fp_mant_normalizer
// PURPOSE
//  2-stage pipelined post-add normalizer for the IEEE754 single-precision datapath.
//  - Takes the raw 32-bit mantissa sum and biased exponent from the adder stage.
//  - Counts leading zeros and shifts the mantissa left so bit 31 is the leading one.
//  - Adjusts the exponent to match.
//  - Drives the 5-bit leading-zero count (lz_sel) to the downstream bit-select/rounding stage.
// PARAMETERS
//  MANT_W  32  mantissa width; fixed at 32 because lz_sel is 5 bits
//  EXP_W   8   biased exponent width
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       async active-low reset
//  in_valid     in   1       input beat valid
//  in_ready     out  1       input beat accepted when in_valid & in_ready
//  in_sign      in   1       sign, passed through
//  in_exp       in   EXP_W   biased exponent of the unnormalized sum
//  in_mant      in   MANT_W  unnormalized mantissa sum
//  out_valid    out  1       output beat valid
//  out_ready    in   1       downstream accepts when out_valid & out_ready
//  out_sign     out  1       registered sign
//  out_exp      out  EXP_W   adjusted exponent
//  out_mant     out  MANT_W  normalized mantissa
//  lz_sel       out  5       applied shift amount
//  out_zero     out  1       input mantissa was all zero
//  out_uflow    out  1       lzc > in_exp; result denormalized
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - Both stage valid bits clear. All out_* and lz_sel = 0. in_ready = 1 after reset.
//   - Reset mid-operation drops in-flight beats; no partial output.
//  Stage 1 (S1), per accepted input: register sign, exp, mant. Compute lzc = leading-zero count of mant (0..31).
//  Stage 2 (S2) computes:
//   - sh       = (lzc > exp) ? exp[4:0] clamped to 31 : lzc
//   - out_mant = mant << sh
//   - out_exp  = exp - sh
//   - lz_sel   = sh
//   - out_uflow = (lzc > exp)
//  Zero mantissa:
//   - out_mant = 0, out_exp = 0, lz_sel = 0, out_zero = 1, out_uflow = 0.
//   - Sign passes through unchanged.
//  Exponent arithmetic: unsigned, EXP_W wide. sh never exceeds exp, so out_exp never wraps.
//  Latency: 2 cycles from accepted input to out_valid when out_ready is held high. Throughput 1 beat/cycle.
//  Handshake:
//   - Each stage advances if it is empty or the stage after it is consuming this cycle.
//   - in_ready  = ~s1_v | (~s2_v | out_ready)
//   - s2 loads when s1_v & (~s2_v | out_ready)
//   - Outputs hold stable while out_valid & ~out_ready.
//   - Simultaneous S2 consume and S1 load in the same cycle is legal: no bubble.
//  in_ready is combinational from out_ready, one level only. No skid buffer.
// STRUCTURE
//  - fp_defs.vh (shared): MANT_W, EXP_W, LZC_W=5, EXP_BIAS=127.
//  - One sub-module, lzc32: combinational 32-bit leading-zero counter.
//    Outputs cnt[4:0] and all_zero. Instantiated in S1.
//  - The shifter is a single left-shift expression in S2. No separate module.
// TESTING
//  1. mant=32'h0000_8000, exp=8'd100, out_ready=1
//     -> 2 cycles later: out_mant=32'h8000_0000, out_exp=84, lz_sel=16, uflow=0.
//  2. mant=32'h8000_0001, exp=8'd5
//     -> out_mant unchanged, out_exp=5, lz_sel=0, zero=0.
//  3. mant=32'h0000_0001, exp=8'd3
//     -> lz_sel=3, out_mant=32'h0000_0008, out_exp=0, uflow=1.
//  4. mant=0, exp=8'd77, sign=1
//     -> out_zero=1, out_mant=0, out_exp=0, out_sign=1.
//  5. Back-to-back stream of 8 beats with out_ready low for cycles 3-5
//     -> in_ready drops once both stages are full; no beat lost or duplicated; order preserved.
//  6. Assert rst_n low while 2 beats are in flight
//     -> out_valid=0 immediately (async); after release in_ready=1 and the next beat arrives 2 cycles later.

Source files
------------

// File: rtl/fp_mant_normalizer_pkg.sv
// Shared widths and stage payload types for the post-add mantissa normalizer.
package fp_mant_normalizer_pkg;

  localparam int unsigned MANT_W   = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned LZC_W    = 5;
  localparam int unsigned EXP_BIAS = 127;

  // One unnormalized beat as captured by stage 1.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_beat_t;

endpackage

// File: rtl/fp_mant_normalizer_lzc32.sv
// Combinational 32-bit leading-zero counter; cnt is 0 when the word is all zero.
module lzc32
  import fp_mant_normalizer_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  output logic [LZC_W-1:0]  cnt,
  output logic              all_zero
);

  // Scan LSB to MSB so the highest set bit makes the final assignment.
  always_comb begin
    cnt      = '0;
    all_zero = ~|mant;
    for (int unsigned i = 0; i < MANT_W; i++) begin
      if (mant[i]) begin
        cnt = LZC_W'(MANT_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_mant_normalizer.sv
// Two-stage post-add normalizer: S1 captures the sum and counts leading zeros,
// S2 shifts the mantissa, adjusts the exponent and flags zero/underflow.
module fp_mant_normalizer
  import fp_mant_normalizer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic [LZC_W-1:0]  lz_sel,
  output logic              out_zero,
  output logic              out_uflow
);

  logic              s1_v_q,    s1_v_d;
  fp_beat_t          s1_beat_q, s1_beat_d;
  logic [LZC_W-1:0]  s1_lzc_q,  s1_lzc_d;
  logic              s1_zero_q, s1_zero_d;

  logic              s2_v_q,     s2_v_d;
  logic              s2_sign_q,  s2_sign_d;
  logic [EXP_W-1:0]  s2_exp_q,   s2_exp_d;
  logic [MANT_W-1:0] s2_mant_q,  s2_mant_d;
  logic [LZC_W-1:0]  s2_lz_q,    s2_lz_d;
  logic              s2_zero_q,  s2_zero_d;
  logic              s2_uflow_q, s2_uflow_d;

  logic              in_fire_c;
  logic              s2_load_c;
  logic [LZC_W-1:0]  in_lzc_c;
  logic              in_zero_c;
  logic              uflow_c;
  logic [LZC_W-1:0]  sh_c;

  lzc32 u_lzc (
    .mant     (in_mant),
    .cnt      (in_lzc_c),
    .all_zero (in_zero_c)
  );

  // Each stage advances when empty or when its successor drains this cycle.
  always_comb begin
    s2_load_c = s1_v_q & (~s2_v_q | out_ready);
    in_ready  = ~s1_v_q | (~s2_v_q | out_ready);
    in_fire_c = in_valid & in_ready;
  end

  always_comb begin
    s1_v_d    = in_fire_c | (s1_v_q & ~s2_load_c);
    s1_beat_d = s1_beat_q;
    s1_lzc_d  = s1_lzc_q;
    s1_zero_d = s1_zero_q;
    if (in_fire_c) begin
      s1_beat_d = '{sign: in_sign, exp: in_exp, mant: in_mant};
      s1_lzc_d  = in_lzc_c;
      s1_zero_d = in_zero_c;
    end
  end

  // Underflow limits the shift to the exponent so the result exponent stops at 0.
  always_comb begin
    uflow_c    = ~s1_zero_q & (EXP_W'(s1_lzc_q) > s1_beat_q.exp);
    sh_c       = uflow_c ? s1_beat_q.exp[LZC_W-1:0] : s1_lzc_q;
    s2_v_d     = s2_load_c | (s2_v_q & ~out_ready);
    s2_sign_d  = s2_sign_q;
    s2_exp_d   = s2_exp_q;
    s2_mant_d  = s2_mant_q;
    s2_lz_d    = s2_lz_q;
    s2_zero_d  = s2_zero_q;
    s2_uflow_d = s2_uflow_q;
    if (s2_load_c) begin
      s2_sign_d  = s1_beat_q.sign;
      s2_zero_d  = s1_zero_q;
      s2_uflow_d = uflow_c;
      if (s1_zero_q) begin
        s2_exp_d  = '0;
        s2_mant_d = '0;
        s2_lz_d   = '0;
      end else begin
        s2_exp_d  = s1_beat_q.exp - EXP_W'(sh_c);
        s2_mant_d = s1_beat_q.mant << sh_c;
        s2_lz_d   = sh_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_beat_q  <= '0;
      s1_lzc_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_mant_q  <= '0;
      s2_lz_q    <= '0;
      s2_zero_q  <= 1'b0;
      s2_uflow_q <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_beat_q  <= s1_beat_d;
      s1_lzc_q   <= s1_lzc_d;
      s1_zero_q  <= s1_zero_d;
      s2_v_q     <= s2_v_d;
      s2_sign_q  <= s2_sign_d;
      s2_exp_q   <= s2_exp_d;
      s2_mant_q  <= s2_mant_d;
      s2_lz_q    <= s2_lz_d;
      s2_zero_q  <= s2_zero_d;
      s2_uflow_q <= s2_uflow_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_sign  = s2_sign_q;
  assign out_exp   = s2_exp_q;
  assign out_mant  = s2_mant_q;
  assign lz_sel    = s2_lz_q;
  assign out_zero  = s2_zero_q;
  assign out_uflow = s2_uflow_q;

endmodule
